// File: rtl/sub8u_pkg.sv
// sub8u_pkg: shared width defaults and FSM state type for the serial recovery unit
package sub8u_pkg;
  localparam int DEF_W = 8;
  localparam int CNT_W = $clog2(DEF_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fsub1.sv
// fsub1: combinational 1-bit full subtractor
module fsub1 (
  input  logic s,
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = s ^ a ^ bin;
  assign bout = (~s & a) | (~(s ^ a) & bin);
endmodule

// File: rtl/sub8u_serial_recover.sv
// sub8u_serial_recover: bit-serial B = S - A recovery with adder-consistency flag
module sub8u_serial_recover
  import sub8u_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   sum_i,
  input  logic [W-1:0] a_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] b_o,
  output logic         err_o,
  output logic         busy_o
);
  localparam int CW = $clog2(W + 1);
  state_t state, state_n;
  logic [W:0] s_sh, a_sh, diff;
  logic [CW-1:0] cnt;
  logic bor, d, bout, last;
  assign last = cnt == CW'(W);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy_o = state != IDLE;
  fsub1 u_fsub (.s(s_sh[0]), .a(a_sh[0]), .bin(bor), .d(d), .bout(bout));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: accept in IDLE, W+1 serial steps in RUN, hold DONE until consumed
  always_comb
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  // serial datapath; the last step's difference bit and borrow go straight to the result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_sh <= '0;
      a_sh <= '0;
      diff <= '0;
      cnt <= '0;
      bor <= 1'b0;
      b_o <= '0;
      err_o <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      s_sh <= sum_i;
      a_sh <= {1'b0, a_i};
      diff <= '0;
      cnt <= '0;
      bor <= 1'b0;
    end else if (state == RUN) begin
      s_sh <= s_sh >> 1;
      a_sh <= a_sh >> 1;
      diff <= {d, diff[W:1]};
      cnt <= cnt + CW'(1);
      bor <= bout;
      if (last) begin
        b_o <= diff[W:1];
        err_o <= bout | d;
      end
    end
endmodule

// File: tb/tb_sub8u_serial_recover.sv
// tb_sub8u_serial_recover: directed table, corner sequences and random back-to-back checks
module tb_sub8u_serial_recover;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W:0] sum_i = '0;
  logic [W-1:0] a_i = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] b_o;
  logic err_o;
  logic busy_o;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [8:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic e;
  } vec_t;

  sub8u_serial_recover dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_i(sum_i), .a_i(a_i), .out_valid(out_valid), .out_ready(out_ready),
    .b_o(b_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [8:0] s, input logic [7:0] a, output int t);
    wait_ready();
    t = cyc;
    sum_i = s;
    a_i = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    vec_t tbl[8];
    int n, t, tp;
    logic [7:0] hb;
    logic he;
    tbl[0] = '{9'h0FF, 8'h7F, 8'h80, 1'b0};
    tbl[1] = '{9'h1FE, 8'hFF, 8'hFF, 1'b0};
    tbl[2] = '{9'h000, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{9'h010, 8'h20, 8'hF0, 1'b1};
    tbl[4] = '{9'h1FF, 8'h00, 8'hFF, 1'b1};
    tbl[5] = '{9'h100, 8'h01, 8'hFF, 1'b0};
    tbl[6] = '{9'h000, 8'h01, 8'hFF, 1'b1};
    tbl[7] = '{9'h1FF, 8'hFF, 8'h00, 1'b1};
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_b", 32'(b_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].s, tbl[i].a, t);
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'd1);
      wait_out(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd9);
      chk($sformatf("v%0d_b", i), 32'(b_o), 32'(tbl[i].b));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].e));
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_done_once", i), 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    send(9'h0FF, 8'h7F, t);
    wait_out(n);
    chk("bp_valid", 32'(out_valid), 32'd1);
    hb = b_o;
    he = err_o;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        sum_i = 9'h010;
        a_i = 8'h20;
        in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_b", 32'(b_o), 32'h80);
      chk("bp_hold_err", 32'(err_o), 32'(he));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_b_initial", 32'(hb), 32'h80);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    repeat (12) @(negedge clk);
    chk("bp_no_stray_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy_o), 32'd0);

    send(9'h0FF, 8'h7F, t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    send(9'h100, 8'h01, t);
    wait_out(n);
    chk("post_rst_latency", 32'(n), 32'd9);
    chk("post_rst_b", 32'(b_o), 32'hFF);
    chk("post_rst_err", 32'(err_o), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);

    tp = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send({1'b0, ra} + {1'b0, rb}, ra, t);
      if (i > 0) chk("rand_interval", 32'(t - tp), 32'(W + 3));
      tp = t;
      wait_out(n);
      chk("rand_valid", 32'(out_valid), 32'd1);
      chk("rand_b", 32'(b_o), 32'(rb));
      chk("rand_err", 32'(err_o), 32'd0);
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
